// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch history table.
`timescale 1ns/1ps
package bp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Counters up to 4 bits are carried in a 4-bit container; the caller truncates.
    function automatic logic [3:0] sat_upd(input logic [3:0] ctr, input logic taken,
                                           input int unsigned ctr_w);
        logic [3:0] ctr_max;
        ctr_max = 4'((5'd1 << ctr_w) - 5'd1);
        if (taken) begin
            sat_upd = (ctr == ctr_max) ? ctr : ctr + 4'd1;
        end else begin
            sat_upd = (ctr == 4'd0) ? ctr : ctr - 4'd1;
        end
    endfunction

    // Index = PC[idx_w:1], optionally XORed with the zero-extended global history.
    function automatic logic [31:0] idx_hash(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int unsigned idx_w, input bit hash_en);
        logic [31:0] mask;
        logic [31:0] base;
        mask = (32'd1 << idx_w) - 32'd1;
        base = (pc >> 1) & mask;
        idx_hash = hash_en ? (base ^ (ghr & mask)) : base;
    endfunction

endpackage

// File: rtl/bht_ram.sv
// Counter array: two asynchronous read ports (lookup and read-modify-write), one synchronous write port.
`timescale 1ns/1ps
module bht_ram #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CTR_W-1:0] wdata,
    input  logic [IDX_W-1:0] ra_addr,
    output logic [CTR_W-1:0] ra_data,
    input  logic [IDX_W-1:0] rb_addr,
    output logic [CTR_W-1:0] rb_data
);

    logic [CTR_W-1:0] mem_q [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/bht_gshare.sv
// Gshare branch history table: registered lookup, speculative GHR with mispredict
// recovery, write-first bypass and a post-reset initialisation sweep.
`timescale 1ns/1ps
module bht_gshare
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned GHR_W    = 8,
    parameter bit          HASH_EN  = 1'b1,
    parameter int unsigned CTR_INIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy,
    input  logic             rd_en,
    input  logic [31:0]      rd_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             up_en,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [GHR_W-1:0] up_ghr,
    input  logic             up_taken,
    input  logic             up_mispredict
);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             pred_valid_q, pred_valid_d;
    logic [CTR_W-1:0] pred_ctr_q, pred_ctr_d;
    logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
    logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

    logic             run;
    logic             upd_act;
    logic             recover;
    logic [IDX_W-1:0] lk_idx;
    logic [CTR_W-1:0] lk_ctr;
    logic [CTR_W-1:0] rmw_ctr;
    logic [CTR_W-1:0] upd_ctr;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [CTR_W-1:0] wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (sweep_q == {IDX_W{1'b1}}) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        init_busy = (state_q == INIT);
        run       = (state_q == RUN);
    end

    assign lk_idx  = IDX_W'(idx_hash(rd_pc, 32'(ghr_q), IDX_W, HASH_EN));
    assign upd_ctr = CTR_W'(sat_upd(4'(rmw_ctr), up_taken, CTR_W));
    assign upd_act = run & up_en;
    assign recover = upd_act & up_mispredict;

    // The sweep and resolved-branch updates share the single write port.
    always_comb begin
        we    = init_busy | upd_act;
        waddr = init_busy ? sweep_q : up_idx;
        wdata = init_busy ? CTR_W'(CTR_INIT) : upd_ctr;
    end

    bht_ram #(
        .IDX_W(IDX_W),
        .CTR_W(CTR_W)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .ra_addr (lk_idx),
        .ra_data (lk_ctr),
        .rb_addr (up_idx),
        .rb_data (rmw_ctr)
    );

    always_comb begin
        sweep_d      = init_busy ? sweep_q + 1'b1 : sweep_q;
        pred_valid_d = run & rd_en & ~recover;
        pred_ctr_d   = pred_ctr_q;
        pred_idx_d   = pred_idx_q;
        pred_ghr_d   = pred_ghr_q;
        if (pred_valid_d) begin
            // Write-first: a same-cycle update to this entry is visible to the lookup.
            pred_ctr_d = (upd_act && (up_idx == lk_idx)) ? upd_ctr : lk_ctr;
            pred_idx_d = lk_idx;
            pred_ghr_d = ghr_q;
        end
        ghr_d = ghr_q;
        if (recover) begin
            ghr_d = GHR_W'({up_ghr, up_taken});
        end else if (pred_valid_q) begin
            ghr_d = GHR_W'({ghr_q, pred_ctr_q[CTR_W-1]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_q      <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
            pred_idx_q   <= '0;
            pred_ghr_q   <= '0;
        end else begin
            sweep_q      <= sweep_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
            pred_idx_q   <= pred_idx_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[CTR_W-1];
    assign pred_idx   = pred_idx_q;
    assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_bht_gshare.sv
// Directed bench for bht_gshare (IDX_W=10, CTR_W=2, GHR_W=8, gshare indexing, CTR_INIT=1).
`timescale 1ns/1ps
module tb_bht_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_busy;
    logic        rd_en;
    logic [31:0] rd_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic [9:0]  pred_idx;
    logic [7:0]  pred_ghr;
    logic        up_en;
    logic [9:0]  up_idx;
    logic [7:0]  up_ghr;
    logic        up_taken;
    logic        up_mispredict;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bht_gshare dut (
        .clk           (clk),
        .rst           (rst),
        .init_busy     (init_busy),
        .rd_en         (rd_en),
        .rd_pc         (rd_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ctr      (pred_ctr),
        .pred_idx      (pred_idx),
        .pred_ghr      (pred_ghr),
        .up_en         (up_en),
        .up_idx        (up_idx),
        .up_ghr        (up_ghr),
        .up_taken      (up_taken),
        .up_mispredict (up_mispredict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_pc = '0;
        up_en = 1'b0; up_idx = '0; up_ghr = '0; up_taken = 1'b0; up_mispredict = 1'b0;
    endtask

    task automatic wait_sweep(input string tag);
        int cnt;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 3000) begin
            tick();
            cnt++;
        end
        check(tag, 32'(cnt), 32'd1024);
    endtask

    // Lookup at pc, check the registered prediction, then one idle cycle so the GHR shift lands.
    task automatic look(input string tag, input logic [31:0] pc, input logic [9:0] e_idx,
                        input logic [1:0] e_ctr, input logic [7:0] e_ghr);
        rd_en = 1'b1; rd_pc = pc;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(pred_valid), 32'd1);
        check({tag, "_idx"},   32'(pred_idx),   32'(e_idx));
        check({tag, "_ctr"},   32'(pred_ctr),   32'(e_ctr));
        check({tag, "_taken"}, 32'(pred_taken), 32'(e_ctr >> 1));
        check({tag, "_ghr"},   32'(pred_ghr),   32'(e_ghr));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_busy",  32'(init_busy),  32'd1);
        check("rst_valid", 32'(pred_valid), 32'd0);
        check("rst_ctr",   32'(pred_ctr),   32'd0);
        check("rst_idx",   32'(pred_idx),   32'd0);
        check("rst_ghr",   32'(pred_ghr),   32'd0);
        rst = 1'b0;
        wait_sweep("sweep1_len");

        // GHR=0: idx = pc[10:1]; every entry starts at 1.
        rd_en = 1'b1; rd_pc = 32'h10;
        tick();
        rd_en = 1'b0;
        check("first_valid", 32'(pred_valid), 32'd1);
        check("first_ctr",   32'(pred_ctr),   32'd1);
        check("first_taken", 32'(pred_taken), 32'd0);
        check("first_idx",   32'(pred_idx),   32'd8);
        tick();
        check("pulse_valid", 32'(pred_valid), 32'd0);

        // Saturate idx 5 upward, read 3; GHR then becomes 1.
        up_en = 1'b1; up_idx = 10'd5; up_taken = 1'b1;
        repeat (4) tick();
        up_en = 1'b0;
        look("sat_hi", 32'h0A, 10'd5, 2'd3, 8'h00);
        up_en = 1'b1; up_idx = 10'd5; up_taken = 1'b0;
        repeat (2) tick();
        up_en = 1'b0;
        // pc field 4 ^ GHR 1 = idx 5; GHR afterwards 0x02.
        look("dec", 32'h08, 10'd5, 2'd1, 8'h01);

        // Recovery {0x52[6:0],1} = 0xA5.
        up_en = 1'b1; up_mispredict = 1'b1; up_idx = 10'd100; up_taken = 1'b1; up_ghr = 8'h52;
        tick();
        idle_inputs();
        look("hash", 32'h40, 10'h085, 2'd1, 8'hA5);
        look("spec", 32'h00, 10'h04A, 2'd1, 8'h4A);

        // GHR now 0x94; mispredict during the prediction's valid cycle wins over the shift.
        rd_en = 1'b1; rd_pc = 32'h0;
        tick();
        rd_en = 1'b0;
        check("pre_rec_valid", 32'(pred_valid), 32'd1);
        check("pre_rec_ghr",   32'(pred_ghr),   32'h94);
        up_en = 1'b1; up_mispredict = 1'b1; up_idx = 10'd200; up_taken = 1'b1; up_ghr = 8'h0F;
        tick();
        idle_inputs();
        look("recover", 32'h00, 10'h01F, 2'd1, 8'h1F);

        // GHR 0x3E; pc field 0x6E hashes to 0x50, concurrent taken update -> bypass sees 2.
        rd_en = 1'b1; rd_pc = 32'hDC; up_en = 1'b1; up_idx = 10'h050; up_taken = 1'b1;
        tick();
        idle_inputs();
        check("byp_valid", 32'(pred_valid), 32'd1);
        check("byp_ctr",   32'(pred_ctr),   32'd2);
        check("byp_taken", 32'(pred_taken), 32'd1);
        check("byp_idx",   32'(pred_idx),   32'h050);

        // Lookup dropped during mispredict; GHR recovers to 0, entry 300 drops to 0.
        rd_en = 1'b1; rd_pc = 32'h258;
        up_en = 1'b1; up_mispredict = 1'b1; up_idx = 10'd300; up_taken = 1'b0; up_ghr = 8'h00;
        tick();
        idle_inputs();
        check("flush_valid", 32'(pred_valid), 32'd0);
        look("e300", 32'h258, 10'd300, 2'd0, 8'h00);
        look("e50", 32'hA0, 10'h050, 2'd2, 8'h00);

        // Reset mid-run, then again mid-sweep at address 300.
        rst = 1'b1;
        #2;
        check("rst2_busy",  32'(init_busy),  32'd1);
        check("rst2_valid", 32'(pred_valid), 32'd0);
        rst = 1'b0;
        repeat (300) tick();
        check("at300_busy", 32'(init_busy), 32'd1);
        rd_en = 1'b1; rd_pc = 32'h258;
        up_en = 1'b1; up_mispredict = 1'b1; up_idx = 10'd7; up_taken = 1'b1; up_ghr = 8'hFF;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        wait_sweep("sweep2_len");
        check("init_ignore_valid", 32'(pred_valid), 32'd0);
        idle_inputs();
        look("post_e300", 32'h258, 10'd300,   2'd1, 8'h00);
        look("post_e5",   32'h0A,  10'd5,     2'd1, 8'h00);
        look("post_e7",   32'h0E,  10'd7,     2'd1, 8'h00);
        look("post_e3ff", 32'h7FE, 10'h3FF,   2'd1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
